// File: rtl/lighthouse_sensor_array.sv
// Lighthouse photodiode sensor array: per-channel decoders, snapshot/fresh/stale tracking
// and an Avalon-MM register file with enable mask and global freeze/clear control.

module lighthouse_sensor (
    input  logic        clock,
    input  logic        reset,
    input  logic        sensor,
    output logic [31:0] combined_data
);
    logic        level_r;
    logic [15:0] width_r;
    logic [15:0] gap_r;
    logic [15:0] gap_at_rise_r;

    // Measure pulse width and rise-to-rise gap; publish {gap, width} on each falling edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            level_r       <= 1'b0;
            width_r       <= 16'h0000;
            gap_r         <= 16'h0000;
            gap_at_rise_r <= 16'h0000;
            combined_data <= 32'h0000_0000;
        end else begin
            level_r <= sensor;
            if (sensor && !level_r) begin
                gap_at_rise_r <= gap_r;
                gap_r         <= 16'h0001;
                width_r       <= 16'h0001;
            end else begin
                if (gap_r != 16'hFFFF) gap_r <= gap_r + 16'h0001;
                if (sensor && (width_r != 16'hFFFF)) width_r <= width_r + 16'h0001;
            end
            if (!sensor && level_r) combined_data <= {gap_at_rise_r, width_r};
        end
    end
endmodule

module lighthouse_sensor_array #(
    parameter int NUM_SENSORS  = 16,
    parameter int ADDR_WIDTH   = 6,
    parameter int STALE_CYCLES = 5_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  address,
    input  logic                   write,
    input  logic [31:0]            writedata,
    input  logic                   read,
    output logic [31:0]            readdata,
    output logic                   waitrequest,
    input  logic [NUM_SENSORS-1:0] sensor_signal_i
);
    localparam int              CW        = $clog2(STALE_CYCLES + 1);
    localparam logic [CW-1:0]   STALE_MAX = CW'(STALE_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [31:0]     A_FRESH   = 32'(NUM_SENSORS);
    localparam logic [31:0]     A_STALE   = 32'(NUM_SENSORS + 1);
    localparam logic [31:0]     A_ENABLE  = 32'(NUM_SENSORS + 2);
    localparam logic [31:0]     A_CONTROL = 32'(NUM_SENSORS + 3);
    localparam logic [31:0]     A_INFO    = 32'(NUM_SENSORS + 4);

    logic [NUM_SENSORS-1:0] sync1_r, sync2_r;
    logic [31:0]            combined_data_s [NUM_SENSORS];
    logic [31:0]            prev_r          [NUM_SENSORS];
    logic [31:0]            snap_r          [NUM_SENSORS];
    logic [CW-1:0]          cnt_r           [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] new_sample_s, stale_s, fresh_r, enable_r;
    logic                   freeze_r, rd_ack_r;
    logic [31:0]            addr_s, rd_mux_s, snap_sel_s;
    logic                   rd_start_s, rd_done_s, clear_s, unused_s;

    assign addr_s      = 32'(address);
    assign rd_start_s  = read & ~rd_ack_r;
    assign rd_done_s   = read & rd_ack_r;
    assign waitrequest = rd_start_s;
    assign clear_s     = write & (addr_s == A_CONTROL) & writedata[1];
    assign unused_s    = ^writedata;

    // Two-stage synchroniser for the asynchronous photodiode envelopes.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= {NUM_SENSORS{1'b0}};
            sync2_r <= {NUM_SENSORS{1'b0}};
        end else begin
            sync1_r <= sensor_signal_i;
            sync2_r <= sync1_r;
        end
    end

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
        logic [31:0] sensor_out_s;
        lighthouse_sensor u_sensor (
            .clock         (clock),
            .reset         (reset),
            .sensor        (sync2_r[i]),
            .combined_data (sensor_out_s)
        );
        assign combined_data_s[i] = sensor_out_s;
        assign new_sample_s[i]    = (combined_data_s[i] != prev_r[i]);
        assign stale_s[i]         = (cnt_r[i] == STALE_MAX);
    end

    // Per-channel change tracking, snapshot load, fresh flags and stale counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            fresh_r <= {NUM_SENSORS{1'b0}};
            for (int i = 0; i < NUM_SENSORS; i++) begin
                prev_r[i] <= 32'h0000_0000;
                snap_r[i] <= 32'h0000_0000;
                cnt_r[i]  <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                prev_r[i] <= combined_data_s[i];
                if (clear_s) begin
                    snap_r[i]  <= 32'h0000_0000;
                    fresh_r[i] <= 1'b0;
                    cnt_r[i]   <= {CW{1'b0}};
                end else begin
                    // A new sample setting fresh outranks a completing read clearing it.
                    if (new_sample_s[i] && enable_r[i] && !freeze_r) begin
                        snap_r[i]  <= combined_data_s[i];
                        fresh_r[i] <= 1'b1;
                    end else if (rd_done_s && (addr_s == 32'(i))) begin
                        fresh_r[i] <= 1'b0;
                    end
                    if (new_sample_s[i] || !enable_r[i]) begin
                        cnt_r[i] <= {CW{1'b0}};
                    end else if (cnt_r[i] != STALE_MAX) begin
                        cnt_r[i] <= cnt_r[i] + CNT_ONE;
                    end
                end
            end
        end
    end

    // Writable control registers: channel enable mask and freeze bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            enable_r <= {NUM_SENSORS{1'b1}};
            freeze_r <= 1'b0;
        end else begin
            if (write && (addr_s == A_ENABLE))  enable_r <= writedata[NUM_SENSORS-1:0];
            if (write && (addr_s == A_CONTROL)) freeze_r <= writedata[0];
        end
    end

    // Read mux; unmapped addresses fall through to the DEAD_BEEF marker.
    always_comb begin
        snap_sel_s = 32'hDEAD_BEEF;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            snap_sel_s = (addr_s == 32'(i)) ? snap_r[i] : snap_sel_s;
        end
        case (addr_s)
            A_FRESH:   rd_mux_s = 32'(fresh_r);
            A_STALE:   rd_mux_s = 32'(stale_s);
            A_ENABLE:  rd_mux_s = 32'(enable_r);
            A_CONTROL: rd_mux_s = {31'h0000_0000, freeze_r};
            A_INFO:    rd_mux_s = {16'h4C48, 16'(NUM_SENSORS)};
            default:   rd_mux_s = snap_sel_s;
        endcase
    end

    // One-wait-state read handshake with registered read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ack_r <= 1'b0;
            readdata <= 32'h0000_0000;
        end else begin
            rd_ack_r <= rd_start_s;
            if (rd_start_s) readdata <= rd_mux_s;
        end
    end
endmodule

// File: tb/tb_lighthouse_sensor_array.sv
// Directed bench for lighthouse_sensor_array (N=4, STALE_CYCLES=16); decoder outputs are forced.

module tb_lighthouse_sensor_array;
    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [3:0]  sensor_signal_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] d, d2;
    int          w, w2;

    always #5 clock = ~clock;

    lighthouse_sensor_array #(.NUM_SENSORS(4), .ADDR_WIDTH(6), .STALE_CYCLES(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .address         (address),
        .write           (write),
        .writedata       (writedata),
        .read            (read),
        .readdata        (readdata),
        .waitrequest     (waitrequest),
        .sensor_signal_i (sensor_signal_i)
    );

    // Bus read starting at a falling edge; returns data and number of wait cycles seen.
    task automatic rd(input logic [5:0] a, output logic [31:0] data, output int wc);
        address = a;
        read    = 1'b1;
        wc      = 0;
        #1;
        while (waitrequest && wc < 8) begin
            wc++;
            @(negedge clock);
            #1;
        end
        data = readdata;
        @(negedge clock);
        read = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] v);
        address   = a;
        writedata = v;
        write     = 1'b1;
        @(negedge clock);
        write     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; read = 1'b0; write = 1'b0; address = 6'd0; writedata = 32'h0;
        sensor_signal_i = 4'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (readdata !== 32'h0 || waitrequest !== 1'b0) begin errors++;
            $display("FAIL reset_outputs got rd=%h wr=%b exp 00000000/0", readdata, waitrequest); end
        @(negedge clock);
        rd(6'd6, d, w);
        checks++; if (d !== 32'h0000_000F || w != 1) begin errors++;
            $display("FAIL reset_enable got %h/%0d exp 0000000f/1", d, w); end
        rd(6'd8, d, w);
        checks++; if (d !== 32'h4C48_0004 || w != 1) begin errors++;
            $display("FAIL reset_info got %h/%0d exp 4c480004/1", d, w); end
        rd(6'd20, d, w);
        checks++; if (d !== 32'hDEAD_BEEF || w != 1) begin errors++;
            $display("FAIL reset_unmapped got %h/%0d exp deadbeef/1", d, w); end
        rd(6'd4, d, w);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL reset_fresh got %h exp 00000000", d); end
        rd(6'd7, d, w);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL reset_control got %h exp 00000000", d); end
        repeat (20) @(negedge clock);
    endtask

    task automatic test_sample_stale();
        force dut.g_ch[2].sensor_out_s = 32'h0001_2345;
        @(negedge clock);
        rd(6'd4, d, w);
        checks++; if (d !== 32'h0000_0004) begin errors++;
            $display("FAIL sample_fresh got %h exp 00000004", d); end
        rd(6'd2, d, w);
        checks++; if (d !== 32'h0001_2345) begin errors++;
            $display("FAIL sample_snap2 got %h exp 00012345", d); end
        rd(6'd4, d, w);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL sample_fresh_cleared got %h exp 00000000", d); end
        // Next read samples with the channel-2 counter at 15, the one after at 16.
        repeat (9) @(negedge clock);
        rd(6'd5, d, w);
        checks++; if (d !== 32'h0000_000B) begin errors++;
            $display("FAIL stale_before got %h exp 0000000b", d); end
        rd(6'd5, d, w);
        checks++; if (d !== 32'h0000_000F) begin errors++;
            $display("FAIL stale_after got %h exp 0000000f", d); end
    endtask

    task automatic test_freeze();
        wr(6'd7, 32'h1);
        force dut.g_ch[0].sensor_out_s = 32'hAAAA_0001;
        @(negedge clock);
        rd(6'd7, d, w);
        checks++; if (d !== 32'h1) begin errors++;
            $display("FAIL freeze_control got %h exp 00000001", d); end
        rd(6'd0, d, w);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL freeze_snap0 got %h exp 00000000", d); end
        rd(6'd4, d, w);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL freeze_fresh got %h exp 00000000", d); end
        wr(6'd7, 32'h0);
        repeat (2) @(negedge clock);
        rd(6'd4, d, w);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL unfreeze_no_queue got %h exp 00000000", d); end
        force dut.g_ch[0].sensor_out_s = 32'hAAAA_0002;
        @(negedge clock);
        rd(6'd4, d, w);
        checks++; if (d !== 32'h1) begin errors++;
            $display("FAIL unfreeze_fresh got %h exp 00000001", d); end
        rd(6'd0, d, w);
        checks++; if (d !== 32'hAAAA_0002) begin errors++;
            $display("FAIL unfreeze_snap0 got %h exp aaaa0002", d); end
    endtask

    task automatic test_disable();
        wr(6'd6, 32'hFFFF_FFFF);
        rd(6'd6, d, w);
        checks++; if (d !== 32'h0000_000F) begin errors++;
            $display("FAIL enable_upper_bits got %h exp 0000000f", d); end
        wr(6'd6, 32'h0000_000E);
        rd(6'd6, d, w);
        checks++; if (d !== 32'h0000_000E) begin errors++;
            $display("FAIL enable_readback got %h exp 0000000e", d); end
        force dut.g_ch[0].sensor_out_s = 32'h1111_1111;
        @(negedge clock);
        rd(6'd0, d, w);
        checks++; if (d !== 32'hAAAA_0002) begin errors++;
            $display("FAIL disable_snap0 got %h exp aaaa0002", d); end
        rd(6'd4, d, w);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL disable_fresh got %h exp 00000000", d); end
        repeat (40) @(negedge clock);
        rd(6'd5, d, w);
        checks++; if (d !== 32'h0000_000E) begin errors++;
            $display("FAIL disable_stale got %h exp 0000000e", d); end
        wr(6'd6, 32'h0000_000F);
    endtask

    task automatic test_simultaneous();
        force dut.g_ch[1].sensor_out_s = 32'h0000_1111;
        @(negedge clock);
        address = 6'd1;
        read    = 1'b1;
        #1;
        checks++; if (waitrequest !== 1'b1) begin errors++;
            $display("FAIL simul_wait_r got %b exp 1", waitrequest); end
        @(negedge clock);
        force dut.g_ch[1].sensor_out_s = 32'h0000_2222;
        #1;
        checks++; if (waitrequest !== 1'b0 || readdata !== 32'h0000_1111) begin errors++;
            $display("FAIL simul_read_old got %h/%b exp 00001111/0", readdata, waitrequest); end
        @(negedge clock);
        read = 1'b0;
        rd(6'd4, d, w);
        checks++; if (d !== 32'h0000_0002) begin errors++;
            $display("FAIL simul_set_wins got %h exp 00000002", d); end
        rd(6'd1, d, w);
        checks++; if (d !== 32'h0000_2222) begin errors++;
            $display("FAIL simul_snap1_new got %h exp 00002222", d); end
        force dut.g_ch[3].sensor_out_s = 32'h0000_3333;
        wr(6'd7, 32'h2);
        rd(6'd3, d, w);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL clear_snap3 got %h exp 00000000", d); end
        rd(6'd4, d, w);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL clear_fresh got %h exp 00000000", d); end
        rd(6'd5, d, w);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL clear_stale got %h exp 00000000", d); end
        rd(6'd1, d, w);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL clear_snap1 got %h exp 00000000", d); end
        rd(6'd7, d, w);
        checks++; if (d !== 32'h0) begin errors++;
            $display("FAIL clear_reads_zero got %h exp 00000000", d); end
    endtask

    task automatic test_back_to_back();
        address = 6'd8;
        read    = 1'b1;
        #1;
        w = waitrequest ? 1 : 0;
        @(negedge clock);
        #1;
        d = readdata;
        w2 = waitrequest ? 1 : 0;
        @(negedge clock);
        address = 6'd6;
        #1;
        checks++; if (w != 1 || w2 != 0 || d !== 32'h4C48_0004) begin errors++;
            $display("FAIL b2b_first got %h/%0d%0d exp 4c480004/10", d, w, w2); end
        w = waitrequest ? 1 : 0;
        @(negedge clock);
        #1;
        d2 = readdata;
        w2 = waitrequest ? 1 : 0;
        @(negedge clock);
        read = 1'b0;
        checks++; if (w != 1 || w2 != 0 || d2 !== 32'h0000_000F) begin errors++;
            $display("FAIL b2b_second got %h/%0d%0d exp 0000000f/10", d2, w, w2); end
    endtask

    task automatic test_reset_mid_read();
        force dut.g_ch[2].sensor_out_s = 32'h0000_5555;
        @(negedge clock);
        address = 6'd2;
        read    = 1'b1;
        reset   = 1'b1;
        release dut.g_ch[0].sensor_out_s;
        release dut.g_ch[1].sensor_out_s;
        release dut.g_ch[2].sensor_out_s;
        release dut.g_ch[3].sensor_out_s;
        #1;
        checks++; if (waitrequest !== 1'b1) begin errors++;
            $display("FAIL rstmid_wait_r got %b exp 1", waitrequest); end
        @(negedge clock);
        read  = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (waitrequest !== 1'b0 || readdata !== 32'h0) begin errors++;
            $display("FAIL rstmid_abort got %h/%b exp 00000000/0", readdata, waitrequest); end
        @(negedge clock);
        rd(6'd4, d, w);
        checks++; if (d !== 32'h0 || w != 1) begin errors++;
            $display("FAIL rstmid_fresh got %h/%0d exp 00000000/1", d, w); end
        rd(6'd2, d, w);
        checks++; if (d !== 32'h0 || w != 1) begin errors++;
            $display("FAIL rstmid_snap2 got %h/%0d exp 00000000/1", d, w); end
        rd(6'd6, d, w);
        checks++; if (d !== 32'h0000_000F) begin errors++;
            $display("FAIL rstmid_enable got %h exp 0000000f", d); end
    endtask

    initial begin
        test_reset();
        test_sample_stale();
        test_freeze();
        test_disable();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
